// File: rtl/alu_pipe_if.sv
// Handshaked operand/result bundle for alu_pipe: operands and op in, registered result and flags out.
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       ALUControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic             illegal;

    modport master (
        output in_valid, a_in, b_in, ALUControl, out_ready,
        input  in_ready, out_valid, ALUResult, N, Z, C, V, illegal
    );

    modport slave (
        input  in_valid, a_in, b_in, ALUControl, out_ready,
        output in_ready, out_valid, ALUResult, N, Z, C, V, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered RV32I ALU with valid/ready flow control and N/Z/C/V flags.
// Define ALU_MUL_EN to add an iterative shift-add multiplier on op 0xA (otherwise 0xA is illegal).
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset_n,
    alu_pipe_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic                    accept;
    logic                    in_rdy;
    logic                    is_mul;
    logic [WIDTH-1:0]        res;
    logic                    c_flag;
    logic                    v_flag;
    logic                    ill;
    logic [WIDTH:0]          sum;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SH_W-1:0]         shamt;

    logic [WIDTH-1:0]        result_p1;
    logic                    vld_p1;
    logic                    n_p1;
    logic                    z_p1;
    logic                    c_p1;
    logic                    v_p1;
    logic                    ill_p1;

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    assign a_s    = bus.a_in;
    assign b_s    = bus.b_in;
    assign shamt  = bus.b_in[SH_W-1:0];
    assign accept = bus.in_valid & in_rdy;

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        ill    = 1'b0;
        is_mul = 1'b0;
        sum    = '0;
        case (bus.ALUControl)
            4'h0: begin
                sum    = {1'b0, bus.a_in} + {1'b0, bus.b_in};
                res    = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                v_flag = add_ovf(bus.a_in[WIDTH-1], bus.b_in[WIDTH-1], sum[WIDTH-1]);
            end
            4'h1: begin
                sum    = {1'b0, bus.a_in} + {1'b0, ~bus.b_in} + (WIDTH+1)'(1);
                res    = sum[WIDTH-1:0];
                c_flag = sum[WIDTH];
                v_flag = add_ovf(bus.a_in[WIDTH-1], ~bus.b_in[WIDTH-1], sum[WIDTH-1]);
            end
            4'h2: res = bus.a_in & bus.b_in;
            4'h3: res = bus.a_in | bus.b_in;
            4'h4: res = bus.a_in ^ bus.b_in;
            4'h5: res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            4'h6: res = {{(WIDTH-1){1'b0}}, (bus.a_in < bus.b_in)};
            4'h7: res = bus.a_in << shamt;
            4'h8: res = bus.a_in >> shamt;
            4'h9: res = a_s >>> shamt;
`ifdef ALU_MUL_EN
            4'hA: is_mul = 1'b1;
`endif
            default: ill = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [SH_W:0]    cnt_q, cnt_d;
    logic             mul_done;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;

    // The extra BUSY cycle after the last partial product hands acc_q to the output stage.
    assign mul_done = (state_q == BUSY) && (cnt_q == (SH_W+1)'(WIDTH));
    assign in_rdy   = (state_q == IDLE) & (~vld_p1 | bus.out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (mul_done) state_d = IDLE;
                else          cnt_d   = cnt_q + (SH_W+1)'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand_q  <= bus.a_in;
            mplier_q <= bus.b_in;
            acc_q    <= '0;
        end else if (state_q == BUSY && !mul_done) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end
`else
    assign in_rdy = ~vld_p1 | bus.out_ready;
`endif

    // Output stage: loads on a single-cycle accept or multiplier completion, holds while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            n_p1      <= 1'b0;
            z_p1      <= 1'b0;
            c_p1      <= 1'b0;
            v_p1      <= 1'b0;
            ill_p1    <= 1'b0;
        end else if (accept && !is_mul) begin
            vld_p1    <= 1'b1;
            result_p1 <= res;
            n_p1      <= res[WIDTH-1];
            z_p1      <= (res == '0);
            c_p1      <= c_flag;
            v_p1      <= v_flag;
            ill_p1    <= ill;
`ifdef ALU_MUL_EN
        end else if (mul_done) begin
            vld_p1    <= 1'b1;
            result_p1 <= acc_q;
            n_p1      <= acc_q[WIDTH-1];
            z_p1      <= (acc_q == '0);
            c_p1      <= 1'b0;
            v_p1      <= 1'b0;
            ill_p1    <= 1'b0;
`endif
        end else if (bus.out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_p1;
    assign bus.ALUResult = result_p1;
    assign bus.N         = n_p1;
    assign bus.Z         = z_p1;
    assign bus.C         = c_p1;
    assign bus.V         = v_p1;
    assign bus.illegal   = ill_p1;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32): arithmetic/flag corners, stall handling, illegal ops, multiplier.
module tb_alu_pipe;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %0s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // flags packed as {N,Z,C,V,illegal}
    function automatic logic [4:0] flags();
        return {bus.N, bus.Z, bus.C, bus.V, bus.illegal};
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic [4:0] exp_f);
        @(posedge clk); #1;
        bus.ALUControl = op;
        bus.a_in       = a;
        bus.b_in       = b;
        bus.in_valid   = 1'b1;
        bus.out_ready  = 1'b1;
        @(negedge clk);
        check({tag, ".rdy"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".vld"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".res"}, 64'(bus.ALUResult), 64'(exp_r));
        check({tag, ".flg"}, 64'(flags()), 64'(exp_f));
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.ALUControl = 4'h0;
        bus.out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.vld", 64'(bus.out_valid), 64'd0);
        check("rst.res", 64'(bus.ALUResult), 64'd0);
        check("rst.flg", 64'(flags()), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        //                          op    a             b             result        NZCVI
        run_op("add_wrap",   4'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b01100);
        run_op("add_ovf",    4'h0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b10010);
        run_op("sub_ovf",    4'h1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b00110);
        run_op("sub_borrow", 4'h1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 5'b10000);
        run_op("sub_eq",     4'h1, 32'h12345678, 32'h12345678, 32'h00000000, 5'b01100);
        run_op("and",        4'h2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 5'b00000);
        run_op("or",         4'h3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 5'b10000);
        run_op("xor",        4'h4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 5'b10000);
        run_op("slt",        4'h5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000);
        run_op("sltu",       4'h6, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 5'b00000);
        run_op("sltu_f",     4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b01000);
        run_op("sll",        4'h7, 32'h00000001, 32'h0000001F, 32'h80000000, 5'b10000);
        run_op("srl",        4'h8, 32'h80000000, 32'h00000004, 32'h08000000, 5'b00000);
        run_op("srl_zero",   4'h8, 32'h12345678, 32'h00000020, 32'h12345678, 5'b00000);
        run_op("sra",        4'h9, 32'h80000000, 32'h00000021, 32'hC0000000, 5'b10000);
        run_op("illegal_b",  4'hB, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b01001);
        run_op("illegal_f",  4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b01001);
`ifndef ALU_MUL_EN
        run_op("illegal_a",  4'hA, 32'h00010001, 32'h00010001, 32'h00000000, 5'b01001);
`endif

        // Stall: first add held while second waits; then accept+drain in one cycle.
        @(posedge clk); #1;
        bus.out_ready  = 1'b0;
        bus.ALUControl = 4'h0;
        bus.a_in       = 32'd1;
        bus.b_in       = 32'd2;
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.a_in = 32'd10;
        bus.b_in = 32'd20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall.rdy", 64'(bus.in_ready), 64'd0);
            check("stall.vld", 64'(bus.out_valid), 64'd1);
            check("stall.res", 64'(bus.ALUResult), 64'd3);
        end
        bus.out_ready = 1'b1;
        #1;
        check("stall.rdy_release", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("stall.vld2", 64'(bus.out_valid), 64'd1);
        check("stall.res2", 64'(bus.ALUResult), 64'd30);
        @(negedge clk);
        check("stall.no_dup", 64'(bus.out_valid), 64'd0);

`ifdef ALU_MUL_EN
        begin
            int busy_bad;
            // Multiply: nothing out for 33 edges, in_ready low throughout.
            @(posedge clk); #1;
            bus.ALUControl = 4'hA;
            bus.a_in       = 32'h00010001;
            bus.b_in       = 32'h00010001;
            bus.in_valid   = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            busy_bad = 0;
            for (int k = 0; k < W + 1; k++) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) busy_bad++;
            end
            check("mul.busy", 64'(busy_bad), 64'd0);
            @(negedge clk);
            check("mul.vld", 64'(bus.out_valid), 64'd1);
            check("mul.res", 64'(bus.ALUResult), 64'h00020001);
            check("mul.flg", 64'(flags()), 64'd0);
            @(negedge clk);

            // Reset in the middle of a multiply aborts it.
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            repeat (5) @(posedge clk);
            #1 reset_n = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b1;
            @(negedge clk);
            check("mul_rst.vld", 64'(bus.out_valid), 64'd0);
            check("mul_rst.rdy", 64'(bus.in_ready), 64'd1);
            busy_bad = 0;
            for (int k = 0; k < W + 4; k++) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b0) busy_bad++;
            end
            check("mul_rst.quiet", 64'(busy_bad), 64'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
